// File: rtl/cam_pkg.sv
// Shared types, sizes and the pixel-packing helper for the OV7670 capture path.
package cam_pkg;

  localparam int unsigned IMG_W  = 176;
  localparam int unsigned IMG_H  = 144;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned X_W    = 8;   // holds 0..IMG_W
  localparam int unsigned Y_W    = 8;   // holds 0..IMG_H

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_VS    = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_LINE       = 3'd3,
    ST_LO         = 3'd4,
    ST_FROZEN     = 3'd5
  } cap_state_e;

  // RGB332 from the top bits of each RGB565 channel: R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [2:0] r_msb,
                                                  input logic [2:0] g_msb,
                                                  input logic [1:0] b_msb);
    return {r_msb, g_msb, b_msb};
  endfunction

endpackage

// File: rtl/cam_line_counter.sv
// Pixel/line position tracking, HREF fall detection, bounds check and write address.
module cam_line_counter
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,       // start of a new frame
  input  logic              active,      // FSM is inside a frame (LINE/LO)
  input  logic              in_lo,       // FSM is waiting for a lo byte
  input  logic              href,
  input  logic              pix_done,    // lo byte accepted this cycle
  output logic              href_fall_c,
  output logic              in_bounds_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic [Y_W-1:0]    y_nxt_c,
  output logic              err_nxt_c
);

  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic           href_q;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           err_q, err_d;

  assign href_fall_c = href_q && !href;
  assign in_bounds_c = (x_q < X_W'(IMG_W)) && (y_q < Y_W'(IMG_H));
  // Only used when in bounds, so the product never exceeds IMG_W*IMG_H-1.
  assign addr_c      = (ADDR_W'(y_q) * IMG_W_A) + ADDR_W'(x_q);
  assign y_nxt_c     = y_d;
  assign err_nxt_c   = err_d;

  // Next position / sticky error; line end has priority over pixel accept.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    err_d = err_q;
    if (clear) begin
      x_d   = '0;
      y_d   = '0;
      err_d = 1'b0;
    end else if (active) begin
      if (href_fall_c) begin
        x_d = '0;
        y_d = (y_q == Y_W'(IMG_H)) ? y_q : y_q + Y_W'(1);
        if (in_lo) err_d = 1'b1;
      end else if (pix_done) begin
        if (in_bounds_c) x_d = x_q + X_W'(1);
        else             err_d = 1'b1;
      end
    end
  end

  // Position, error and HREF history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      href_q <= href;
      x_q    <= x_d;
      y_q    <= y_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/camera_capture_ctrl.sv
// OV7670 capture sequencer: frame sync FSM, byte pairing and frame-buffer write port.
module camera_capture_ctrl
  import cam_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        PIX_IN,
  input  logic              CONTINUOUS,
  input  logic              CAP_REQ,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              FRAME_OK,
  output logic              FROZEN
);

  cap_state_e        state_q, state_d;
  logic [5:0]        hi_q, hi_d;        // {R[4:2], G[5:3]} of the pending pixel
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frozen_q, frozen_d;

  logic              cnt_clear, cnt_active, cnt_in_lo, pix_done;
  logic              href_fall_c, in_bounds_c, err_nxt_c;
  logic [ADDR_W-1:0] addr_c;
  logic [Y_W-1:0]    y_nxt_c;

  assign cnt_clear  = (state_q == ST_WAIT_START);
  assign cnt_in_lo  = (state_q == ST_LO);
  assign cnt_active = (state_q == ST_LINE) || cnt_in_lo;
  assign pix_done   = cnt_in_lo && HREF && !VSYNC;

  cam_line_counter u_line_counter (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .clear       (cnt_clear),
    .active      (cnt_active),
    .in_lo       (cnt_in_lo),
    .href        (HREF),
    .pix_done    (pix_done),
    .href_fall_c (href_fall_c),
    .in_bounds_c (in_bounds_c),
    .addr_c      (addr_c),
    .y_nxt_c     (y_nxt_c),
    .err_nxt_c   (err_nxt_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frozen_d     = frozen_q;
    case (state_q)
      ST_IDLE: begin
        if (CONTINUOUS || CAP_REQ) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        // Only start after a full VSYNC pulse so a frame is never joined midway.
        if (VSYNC) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!VSYNC) state_d = ST_LINE;
      end
      ST_LINE, ST_LO: begin
        if (VSYNC) begin
          // y_nxt_c/err_nxt_c already include a coincident HREF fall.
          frame_done_d = 1'b1;
          frame_ok_d   = (y_nxt_c == Y_W'(IMG_H)) && !err_nxt_c;
          if (CONTINUOUS) begin
            state_d = ST_WAIT_START;
          end else begin
            state_d  = ST_FROZEN;
            frozen_d = 1'b1;
          end
        end else if (state_q == ST_LINE) begin
          if (HREF) begin
            hi_d    = {PIX_IN[7:5], PIX_IN[2:0]};
            state_d = ST_LO;
          end
        end else if (href_fall_c) begin
          // Odd byte count: drop the orphan hi byte, counter flags the error.
          state_d = ST_LINE;
        end else if (HREF) begin
          state_d = ST_LINE;
          if (in_bounds_c) begin
            w_en_d   = 1'b1;
            w_addr_d = addr_c;
            w_data_d = rgb565_to_rgb332(hi_q[5:3], hi_q[2:0], PIX_IN[4:3]);
          end
        end
      end
      ST_FROZEN: begin
        if (CAP_REQ || CONTINUOUS) begin
          frozen_d = 1'b0;
          state_d  = ST_WAIT_VS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears the write strobe immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frozen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frozen_q     <= frozen_d;
    end
  end

  assign W_EN       = w_en_q;
  assign W_ADDR     = w_addr_q;
  assign W_DATA     = w_data_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_OK   = frame_ok_q;
  assign FROZEN     = frozen_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Scoreboard bench for camera_capture_ctrl: expected writes queued as bytes are driven.
module tb_camera_capture_ctrl;

  localparam int PW = 176;
  localparam int PH = 144;

  logic        clk = 1'b0;
  logic        RESET_N, VSYNC, HREF, CONTINUOUS, CAP_REQ;
  logic [7:0]  PIX_IN;
  logic [14:0] W_ADDR;
  logic [7:0]  W_DATA;
  logic        W_EN, FRAME_DONE, FRAME_OK, FROZEN;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        last_ok = 1'b0;
  logic [14:0] last_addr = '0;

  always #5 clk = ~clk;

  camera_capture_ctrl dut (
    .CLK        (clk),
    .RESET_N    (RESET_N),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .PIX_IN     (PIX_IN),
    .CONTINUOUS (CONTINUOUS),
    .CAP_REQ    (CAP_REQ),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .W_EN       (W_EN),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_OK   (FRAME_OK),
    .FROZEN     (FROZEN)
  );

  function automatic logic [7:0] ref_pix(input logic [7:0] h, input logic [7:0] l);
    logic [15:0] rgb;
    rgb = {h, l};
    return {3'(rgb[15:11] >> 2), 3'(rgb[10:5] >> 3), 2'(rgb[4:0] >> 3)};
  endfunction

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (W_EN === 1'b1) begin
      wr_cnt++;
      last_addr = W_ADDR;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h expected no write", W_ADDR, W_DATA);
      end else begin
        e = exp_q.pop_front();
        if ({W_ADDR, W_DATA} !== {e.addr, e.data}) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   W_ADDR, W_DATA, e.addr, e.data);
        end
      end
    end
    if (FRAME_DONE === 1'b1) begin
      done_cnt++;
      last_ok = FRAME_OK;
    end
  end

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] px);
    VSYNC  = vs;
    HREF   = hr;
    PIX_IN = px;
    @(posedge clk);
    #1;
  endtask

  // Blanking, nlines lines, line gaps, then VSYNC high to end the frame.
  task automatic send_frame(input int nlines, input int nbytes, input int short_line,
                            input int short_bytes, input bit cap, input bit fixed);
    logic [7:0] h, l;
    int nb;
    h = '0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    for (int ln = 0; ln < nlines; ln++) begin
      nb = (ln == short_line) ? short_bytes : nbytes;
      for (int b = 0; b < nb; b++) begin
        if ((b % 2) == 0) begin
          h = fixed ? 8'hF8 : 8'($urandom);
          cyc(1'b0, 1'b1, h);
        end else begin
          l = fixed ? 8'h1F : 8'($urandom);
          if (cap && (b / 2) < PW && ln < PH)
            exp_q.push_back('{addr: 15'(ln * PW + b / 2), data: ref_pix(h, l)});
          cyc(1'b0, 1'b1, l);
        end
      end
      repeat (4) cyc(1'b0, 1'b0, 8'h00);
    end
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_frame(input string name, input int w0, input int d0, input int exp_wr,
                           input int exp_done);
    total++;
    if (wr_cnt - w0 !== exp_wr) begin
      bad++;
      $display("FAIL %s_writes got=%0d expected=%0d", name, wr_cnt - w0, exp_wr);
    end
    total++;
    if (done_cnt - d0 !== exp_done) begin
      bad++;
      $display("FAIL %s_done got=%0d expected=%0d", name, done_cnt - d0, exp_done);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CONTINUOUS = 1'b0; CAP_REQ = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    total++;
    if ({W_EN, W_ADDR, W_DATA, FRAME_DONE, FRAME_OK, FROZEN} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%0d data=%h done=%b ok=%b frozen=%b expected all 0",
               W_EN, W_ADDR, W_DATA, FRAME_DONE, FRAME_OK, FROZEN);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] h, l;
    int w0, d0;
    h = '0;
    CONTINUOUS = 1'b1;
    RESET_N    = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 10; b++) begin
      if ((b % 2) == 0) begin
        h = 8'($urandom);
        cyc(1'b0, 1'b1, h);
      end else begin
        l = 8'($urandom);
        if (b < 9) exp_q.push_back('{addr: 15'(b / 2), data: ref_pix(h, l)});
        cyc(1'b0, 1'b1, l);
      end
    end
    total++;
    if (W_EN !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_write got=%b expected=1", W_EN);
    end
    RESET_N = 1'b0;
    #1;
    total++;
    if (W_EN !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_wen got=%b expected=0", W_EN);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL pre_reset_pending got=%0d expected=0", exp_q.size());
    end
    repeat (4) cyc(1'b0, 1'b1, 8'($urandom));
    w0 = wr_cnt; d0 = done_cnt;
    RESET_N = 1'b1;
    repeat (20) cyc(1'b0, 1'b1, 8'($urandom));
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    repeat (20) cyc(1'b0, 1'b1, 8'($urandom));
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    total++;
    if (wr_cnt - w0 !== 0) begin
      bad++;
      $display("FAIL partial_frame_writes got=%0d expected=0", wr_cnt - w0);
    end
    send_frame(2, 352, -1, 0, 1'b1, 1'b0);
    chk_frame("after_reset", w0, d0, 352, 1);
    total++;
    if (last_ok !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_ok got=%b expected=0", last_ok);
    end
  endtask

  task automatic test_truncated();
    int w0 = wr_cnt, d0 = done_cnt;
    send_frame(20, 352, -1, 0, 1'b1, 1'b0);
    chk_frame("truncated", w0, d0, 20 * PW, 1);
    total++;
    if ({last_ok, FRAME_OK} !== 2'b00) begin
      bad++;
      $display("FAIL truncated_ok got=%b/%b expected=0/0", last_ok, FRAME_OK);
    end
  endtask

  task automatic test_full_frame();
    int w0 = wr_cnt, d0 = done_cnt;
    send_frame(PH, 352, -1, 0, 1'b1, 1'b1);
    chk_frame("full", w0, d0, PW * PH, 1);
    total++;
    if ({last_ok, FRAME_OK} !== 2'b11) begin
      bad++;
      $display("FAIL full_ok got=%b/%b expected=1/1", last_ok, FRAME_OK);
    end
    total++;
    if (last_addr !== 15'd25343) begin
      bad++;
      $display("FAIL full_last_addr got=%0d expected=25343", last_addr);
    end
    total++;
    if (W_DATA !== 8'hE3) begin
      bad++;
      $display("FAIL full_data got=%h expected=e3", W_DATA);
    end
  endtask

  task automatic test_wide_line();
    int w0 = wr_cnt, d0 = done_cnt;
    send_frame(3, 360, -1, 0, 1'b1, 1'b0);
    chk_frame("wide", w0, d0, 3 * PW, 1);
    total++;
    if (last_addr !== 15'(3 * PW - 1)) begin
      bad++;
      $display("FAIL wide_last_addr got=%0d expected=%0d", last_addr, 3 * PW - 1);
    end
    total++;
    if (last_ok !== 1'b0) begin
      bad++;
      $display("FAIL wide_ok got=%b expected=0", last_ok);
    end
  endtask

  task automatic test_odd_line();
    int w0 = wr_cnt, d0 = done_cnt;
    send_frame(12, 352, 10, 351, 1'b1, 1'b0);
    chk_frame("odd", w0, d0, 11 * PW + 175, 1);
    total++;
    if (last_ok !== 1'b0) begin
      bad++;
      $display("FAIL odd_ok got=%b expected=0", last_ok);
    end
  endtask

  task automatic test_single_shot();
    int w0, d0;
    RESET_N = 1'b0;
    CONTINUOUS = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    RESET_N = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    CAP_REQ = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    CAP_REQ = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(2, 352, -1, 0, 1'b1, 1'b0);
    chk_frame("shot1", w0, d0, 352, 1);
    total++;
    if (FROZEN !== 1'b1) begin
      bad++;
      $display("FAIL shot1_frozen got=%b expected=1", FROZEN);
    end
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(2, 352, -1, 0, 1'b0, 1'b0);
    send_frame(2, 352, -1, 0, 1'b0, 1'b0);
    chk_frame("frozen", w0, d0, 0, 0);
    total++;
    if (FROZEN !== 1'b1) begin
      bad++;
      $display("FAIL frozen_hold got=%b expected=1", FROZEN);
    end
    CAP_REQ = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    CAP_REQ = 1'b0;
    total++;
    if (FROZEN !== 1'b0) begin
      bad++;
      $display("FAIL rearm_frozen got=%b expected=0", FROZEN);
    end
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(2, 352, -1, 0, 1'b1, 1'b0);
    chk_frame("shot2", w0, d0, 352, 1);
    total++;
    if (FROZEN !== 1'b1) begin
      bad++;
      $display("FAIL shot2_frozen got=%b expected=1", FROZEN);
    end
    // Continuous enabled then dropped before the frame: that frame still completes.
    CONTINUOUS = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    CONTINUOUS = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(1, 352, -1, 0, 1'b1, 1'b0);
    chk_frame("cont_drop", w0, d0, 176, 1);
    total++;
    if (FROZEN !== 1'b1) begin
      bad++;
      $display("FAIL cont_drop_frozen got=%b expected=1", FROZEN);
    end
  endtask

  initial begin
    RESET_N = 1'b0; VSYNC = 1'b1; HREF = 1'b0; PIX_IN = 8'h00;
    CONTINUOUS = 1'b0; CAP_REQ = 1'b0;
    test_reset();
    test_reset_mid();
    test_truncated();
    test_full_frame();
    test_wide_line();
    test_odd_line();
    test_single_shot();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
